// File: rtl/sdram_arbiter_pkg.sv
// Shared definitions for the SDRAM arbiter and the SDRAM controller wrapper.
// Holds the arbiter state encoding, the priority flag encoding and the default
// address/data widths of the controller port.
package sdram_arbiter_pkg;

    localparam int ADDR_W_DEF = 22;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        VGA_ISSUE = 3'd1,
        VGA_DRAIN = 3'd2,
        CPU_CMD   = 3'd3,
        CPU_WAIT  = 3'd4,
        CPU_DONE  = 3'd5
    } arb_state_e;

    typedef enum logic {
        PRIO_VGA = 1'b0,
        PRIO_CPU = 1'b1
    } arb_prio_e;

endpackage

// File: rtl/sdram_arb_pending_ctr.sv
// In-flight read counter for the SDRAM controller port.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   inc_i          : a read command was accepted this cycle
//   dec_i          : read data returned this cycle
//   full_o         : MAX_PENDING reads are in flight, no new read may issue
// A return with nothing in flight (stray data) leaves the count at zero.
module sdram_arb_pending_ctr #(
    parameter int MAX_PENDING = 7
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o
);

    localparam int CNT_W = $clog2(MAX_PENDING + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full_o = (cnt_q == CNT_W'(MAX_PENDING));

endmodule

// File: rtl/sdram_arbiter.sv
// Arbiter sharing the pipelined SDRAM controller port between the VGA
// line-fetch engine (bursts, granted first, never interrupted) and the CPU
// load/store path (single accesses). Priority alternates so the CPU gets one
// access between consecutive VGA bursts.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   cpu_*                  : CPU request (held until cpu_ack), ack pulse, read data
//   vga_*                  : burst request (held until vga_done), data stream, done pulse
//   sd_*                   : controller command/write port and read-return port
// Optional build macro SDRAM_ARB_STATS_EN adds stat_cpu_wait_max (longest
// cpu_req-rise-to-ack wait, saturating) and stat_vga_bursts (wrapping count).
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int LEN_W       = 10,
    parameter int MAX_PENDING = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [1:0]        cpu_be,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    input  logic [LEN_W-1:0]  vga_len,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_data_valid,
    output logic              vga_done,
    output logic [ADDR_W-1:0] sd_addr,
    output logic              sd_read,
    output logic              sd_write,
    output logic [DATA_W-1:0] sd_wdata,
    output logic [1:0]        sd_be,
    input  logic              sd_waitrequest,
    input  logic [DATA_W-1:0] sd_rdata,
`ifdef SDRAM_ARB_STATS_EN
    output logic [15:0]       stat_cpu_wait_max,
    output logic [15:0]       stat_vga_bursts,
`endif
    input  logic              sd_rdvalid
);

    arb_state_e        state_q, state_d;
    arb_prio_e         prio_q, prio_d;
    logic [LEN_W-1:0]  issue_q, issue_d;
    logic [LEN_W-1:0]  ret_q, ret_d;
    logic              vga_done_q, vga_done_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

    // Request latches; their contents only reach the outputs in the states
    // that use them, so they need no reset.
    logic [ADDR_W-1:0] vga_addr_q, vga_addr_d;
    logic [LEN_W-1:0]  vga_len_q, vga_len_d;
    logic              cpu_we_q, cpu_we_d;
    logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
    logic [DATA_W-1:0] cpu_wdata_q, cpu_wdata_d;
    logic [1:0]        cpu_be_q, cpu_be_d;

    logic rd_accept;
    logic rd_full;

    sdram_arb_pending_ctr #(
        .MAX_PENDING(MAX_PENDING)
    ) u_pending (
        .clk_i  (clk),
        .reset_i(reset),
        .inc_i  (rd_accept),
        .dec_i  (sd_rdvalid),
        .full_o (rd_full)
    );

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        issue_d     = issue_q;
        ret_d       = ret_q;
        vga_done_d  = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        vga_addr_d  = vga_addr_q;
        vga_len_d   = vga_len_q;
        cpu_we_d    = cpu_we_q;
        cpu_addr_d  = cpu_addr_q;
        cpu_wdata_d = cpu_wdata_q;
        cpu_be_d    = cpu_be_q;

        rd_accept      = 1'b0;
        sd_read        = 1'b0;
        sd_write       = 1'b0;
        sd_addr        = '0;
        sd_wdata       = '0;
        sd_be          = '0;
        cpu_ack        = 1'b0;
        vga_data_valid = 1'b0;
        vga_data       = '0;

        // Burst data is forwarded straight through with no register stage.
        if ((state_q == VGA_ISSUE) || (state_q == VGA_DRAIN)) begin
            vga_data_valid = sd_rdvalid;
            vga_data       = sd_rdvalid ? sd_rdata : '0;
            if (sd_rdvalid) begin
                ret_d = ret_q + LEN_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                // While vga_done is showing, the VGA requester has not yet had
                // a chance to drop vga_req, so it must not be regranted.
                if (vga_req && !vga_done_q && ((prio_q == PRIO_VGA) || !cpu_req)) begin
                    vga_addr_d = vga_addr;
                    vga_len_d  = vga_len;
                    issue_d    = '0;
                    ret_d      = '0;
                    state_d    = (vga_len == '0) ? VGA_DRAIN : VGA_ISSUE;
                end else if (cpu_req) begin
                    cpu_we_d    = cpu_we;
                    cpu_addr_d  = cpu_addr;
                    cpu_wdata_d = cpu_wdata;
                    cpu_be_d    = cpu_be;
                    state_d     = CPU_CMD;
                end
            end
            VGA_ISSUE: begin
                // rd_full only falls while stalled, so a raised command stays up.
                sd_read = !rd_full;
                sd_addr = vga_addr_q + ADDR_W'(issue_q);
                if (sd_read && !sd_waitrequest) begin
                    rd_accept = 1'b1;
                    issue_d   = issue_q + LEN_W'(1);
                    if (issue_d == vga_len_q) begin
                        state_d = VGA_DRAIN;
                    end
                end
            end
            VGA_DRAIN: begin
                if (ret_q == vga_len_q) begin
                    vga_done_d = 1'b1;
                    prio_d     = PRIO_CPU;
                    state_d    = IDLE;
                end
            end
            CPU_CMD: begin
                sd_addr = cpu_addr_q;
                sd_be   = cpu_be_q;
                if (cpu_we_q) begin
                    sd_write = 1'b1;
                    sd_wdata = cpu_wdata_q;
                    if (!sd_waitrequest) begin
                        state_d = CPU_DONE;
                    end
                end else begin
                    sd_read = !rd_full;
                    if (sd_read && !sd_waitrequest) begin
                        rd_accept = 1'b1;
                        state_d   = CPU_WAIT;
                    end
                end
            end
            CPU_WAIT: begin
                if (sd_rdvalid) begin
                    cpu_rdata_d = sd_rdata;
                    state_d     = CPU_DONE;
                end
            end
            CPU_DONE: begin
                cpu_ack = 1'b1;
                prio_d  = PRIO_VGA;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            prio_q      <= PRIO_VGA;
            issue_q     <= '0;
            ret_q       <= '0;
            vga_done_q  <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            issue_q     <= issue_d;
            ret_q       <= ret_d;
            vga_done_q  <= vga_done_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        vga_addr_q  <= vga_addr_d;
        vga_len_q   <= vga_len_d;
        cpu_we_q    <= cpu_we_d;
        cpu_addr_q  <= cpu_addr_d;
        cpu_wdata_q <= cpu_wdata_d;
        cpu_be_q    <= cpu_be_d;
    end

    assign vga_done  = vga_done_q;
    assign cpu_rdata = cpu_rdata_q;

`ifdef SDRAM_ARB_STATS_EN
    logic        cpu_req_prev_q;
    logic        wait_act_q;
    logic [15:0] wait_cnt_q;
    logic [15:0] wait_max_q;
    logic [15:0] bursts_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_req_prev_q <= 1'b0;
            wait_act_q     <= 1'b0;
            wait_cnt_q     <= '0;
            wait_max_q     <= '0;
            bursts_q       <= '0;
        end else begin
            cpu_req_prev_q <= cpu_req;
            if (vga_done_q) begin
                bursts_q <= bursts_q + 16'd1;
            end
            if (cpu_ack) begin
                wait_act_q <= 1'b0;
                if (wait_cnt_q > wait_max_q) begin
                    wait_max_q <= wait_cnt_q;
                end
            end else if (cpu_req && !cpu_req_prev_q) begin
                wait_act_q <= 1'b1;
                wait_cnt_q <= 16'd1;
            end else if (wait_act_q && (wait_cnt_q != 16'hFFFF)) begin
                wait_cnt_q <= wait_cnt_q + 16'd1;
            end
        end
    end

    assign stat_cpu_wait_max = wait_max_q;
    assign stat_vga_bursts   = bursts_q;
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed testbench for sdram_arbiter with a latency-programmable SDRAM
// controller model and expected-value queues for VGA addresses/data.
module tb_sdram_arbiter;

    localparam int ADDR_W      = 22;
    localparam int DATA_W      = 16;
    localparam int LEN_W       = 10;
    localparam int MAX_PENDING = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [1:0]        cpu_be;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [LEN_W-1:0]  vga_len;
    logic [DATA_W-1:0] vga_data;
    logic              vga_data_valid, vga_done;
    logic [ADDR_W-1:0] sd_addr;
    logic              sd_read, sd_write;
    logic [DATA_W-1:0] sd_wdata;
    logic [1:0]        sd_be;
    logic              sd_waitrequest;
    logic [DATA_W-1:0] sd_rdata;
    logic              sd_rdvalid;
`ifdef SDRAM_ARB_STATS_EN
    logic [15:0]       stat_cpu_wait_max, stat_vga_bursts;
`endif

    always #5 clk = ~clk;

    sdram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_PENDING(MAX_PENDING)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_len(vga_len), .vga_data(vga_data),
        .vga_data_valid(vga_data_valid), .vga_done(vga_done),
        .sd_addr(sd_addr), .sd_read(sd_read), .sd_write(sd_write), .sd_wdata(sd_wdata),
        .sd_be(sd_be), .sd_waitrequest(sd_waitrequest), .sd_rdata(sd_rdata),
`ifdef SDRAM_ARB_STATS_EN
        .stat_cpu_wait_max(stat_cpu_wait_max), .stat_vga_bursts(stat_vga_bursts),
`endif
        .sd_rdvalid(sd_rdvalid)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                due;
    } ret_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ret_t              rq[$];
    logic [ADDR_W-1:0] addr_exp[$];
    logic [DATA_W-1:0] vga_exp[$];
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

    int rd_lat = 3;
    int wait_mode = 0;
    int outstanding = 0, max_out = 0;
    int rd_acc_cnt = 0, wr_cnt = 0, valid_cnt = 0;
    int vga_done_cnt = 0, cpu_ack_cnt = 0;
    int done_cyc = 0, ack_cyc = 0, wr_acc_cyc = 0, last_rdv_cyc = 0, first_rd_cyc = -1;
    logic              cpu_rd_exp = 1'b0;
    logic [ADDR_W-1:0] cpu_exp_addr = '0;
    logic [ADDR_W-1:0] last_wr_addr = '0;
    logic [DATA_W-1:0] last_wr_data = '0, ack_rdata = '0;
    logic [1:0]        last_wr_be = '0;

    function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
        if (mem.exists(a)) return mem[a];
        return a[15:0] ^ 16'h5A3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic push_vga(input logic [ADDR_W-1:0] a);
        addr_exp.push_back(a);
        vga_exp.push_back(data_of(a));
    endtask

    // One clock: drive controller-side inputs, then observe the DUT.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        sd_waitrequest = (wait_mode != 0) ? cyc[0] : 1'b0;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            sd_rdvalid = 1'b1;
            sd_rdata   = data_of(rq[0].addr);
            void'(rq.pop_front());
            outstanding--;
            last_rdv_cyc = cyc;
        end else begin
            sd_rdvalid = 1'b0;
            sd_rdata   = '0;
        end
        #1;
        if (sd_read && !sd_waitrequest) begin
            rd_acc_cnt++;
            outstanding++;
            if (outstanding > max_out) max_out = outstanding;
            check("pending_within_max", outstanding <= MAX_PENDING, 1);
            rq.push_back('{addr: sd_addr, due: cyc + rd_lat});
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            if (addr_exp.size() > 0) begin
                check("vga_rd_addr", sd_addr, addr_exp.pop_front());
            end else if (cpu_rd_exp) begin
                check("cpu_rd_addr", sd_addr, cpu_exp_addr);
                cpu_rd_exp = 1'b0;
            end else begin
                check("unexpected_read", sd_read, 1'b0);
            end
        end
        if (sd_write && !sd_waitrequest) begin
            wr_cnt++;
            mem[sd_addr] = sd_wdata;
            last_wr_addr = sd_addr;
            last_wr_data = sd_wdata;
            last_wr_be   = sd_be;
            wr_acc_cyc   = cyc;
        end
        if (vga_data_valid) begin
            valid_cnt++;
            if (vga_exp.size() > 0) check("vga_data", vga_data, vga_exp.pop_front());
            else check("unexpected_vga_valid", vga_data_valid, 1'b0);
        end
        if (vga_done) begin
            vga_done_cnt++;
            done_cyc = cyc;
            vga_req  = 1'b0;
        end
        if (cpu_ack) begin
            cpu_ack_cnt++;
            ack_cyc   = cyc;
            ack_rdata = cpu_rdata;
            cpu_req   = 1'b0;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_until(input int done_tgt, input int ack_tgt, input int budget, input string tag);
        int n;
        n = 0;
        while ((vga_done_cnt < done_tgt || cpu_ack_cnt < ack_tgt) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_in_time"}, (vga_done_cnt >= done_tgt) && (cpu_ack_cnt >= ack_tgt), 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {sd_read, sd_write, cpu_ack, vga_done, vga_data_valid, sd_be}, 0);
        check({tag, "_sd_addr"}, sd_addr, 0);
        check({tag, "_wdata_rdata"}, {sd_wdata, cpu_rdata}, 0);
        check({tag, "_vga_data"}, vga_data, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, a0, r0, v0, req_cyc;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
        vga_req = 1'b0; vga_addr = '0; vga_len = '0;
        sd_waitrequest = 1'b0; sd_rdata = '0; sd_rdvalid = 1'b0;
        ticks(3);
        check_zero("reset");
        reset = 1'b0;
        tick();

        // CPU write 0xBEEF to 0x000100
        cpu_we = 1'b1; cpu_addr = 22'h000100; cpu_wdata = 16'hBEEF; cpu_be = 2'b11; cpu_req = 1'b1;
        run_until(0, 1, 30, "wr");
        check("wr_ack_latency", ack_cyc - wr_acc_cyc, 1);
        ticks(3);
        check("wr_count", wr_cnt, 1);
        check("wr_addr", last_wr_addr, 22'h000100);
        check("wr_data", last_wr_data, 16'hBEEF);
        check("wr_be", last_wr_be, 2'b11);
        check("wr_single_ack", cpu_ack_cnt, 1);

        // CPU read back
        cpu_we = 1'b0; cpu_rd_exp = 1'b1; cpu_exp_addr = 22'h000100; cpu_req = 1'b1;
        run_until(0, 2, 30, "rd");
        check("rd_data", ack_rdata, 16'hBEEF);
        check("rd_ack_latency", ack_cyc - last_rdv_cyc, 1);
        ticks(3);
        check("rd_single_ack", cpu_ack_cnt, 2);

        // VGA burst wrapping the address space, stalls every other cycle
        wait_mode = 1;
        push_vga(22'h3FFFFE); push_vga(22'h3FFFFF); push_vga(22'h000000); push_vga(22'h000001);
        v0 = valid_cnt;
        vga_addr = 22'h3FFFFE; vga_len = 10'd4; vga_req = 1'b1;
        run_until(1, 2, 100, "wrap_burst");
        check("wrap_valid_count", valid_cnt - v0, 4);
        check("wrap_addr_left", addr_exp.size(), 0);
        ticks(4);
        check("wrap_single_done", vga_done_cnt, 1);
        wait_mode = 0;

        // Zero-length burst: no command, done two cycles after grant
        r0 = rd_acc_cnt;
        vga_addr = 22'h000400; vga_len = 10'd0; vga_req = 1'b1; req_cyc = cyc;
        run_until(2, 2, 20, "len0");
        check("len0_done_latency", done_cyc - req_cyc, 2);
        check("len0_no_cmd", rd_acc_cnt - r0, 0);
        ticks(3);

        // Simultaneous requests from reset: VGA first, then CPU, then next burst
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        d0 = vga_done_cnt; a0 = cpu_ack_cnt;
        for (int i = 0; i < 8; i++) push_vga(22'h000200 + 22'(i));
        vga_addr = 22'h000200; vga_len = 10'd8; vga_req = 1'b1;
        cpu_we = 1'b0; cpu_addr = 22'h000100; cpu_rd_exp = 1'b1; cpu_exp_addr = 22'h000100; cpu_req = 1'b1;
        run_until(d0 + 1, a0, 100, "both_burst1");
        check("both_cpu_waits_burst", cpu_ack_cnt, a0);
        vga_addr = 22'h000300; vga_len = 10'd2; vga_req = 1'b1;
        run_until(d0 + 1, a0 + 1, 100, "both_cpu");
        check("both_cpu_right_after", ack_cyc - done_cyc, 5);
        check("both_second_burst_waits", vga_done_cnt, d0 + 1);
        check("both_cpu_data", ack_rdata, 16'hBEEF);
        push_vga(22'h000300); push_vga(22'h000301);
        run_until(d0 + 2, a0 + 1, 100, "both_burst2");
        ticks(4);

        // Long read latency: throttle at MAX_PENDING, all 20 words return
        rd_lat = 12; max_out = 0; v0 = valid_cnt; d0 = vga_done_cnt; first_rd_cyc = -1;
        for (int i = 0; i < 20; i++) push_vga(22'h001000 + 22'(i));
        vga_addr = 22'h001000; vga_len = 10'd20; vga_req = 1'b1; req_cyc = cyc;
        run_until(d0 + 1, cpu_ack_cnt, 400, "lat12");
        check("lat12_start_latency", first_rd_cyc - req_cyc, 1);
        check("lat12_max_pending", max_out, MAX_PENDING);
        check("lat12_all_words", valid_cnt - v0, 20);
        ticks(4);

        // Reset after 3 of 8 reads
        rd_lat = 5; r0 = rd_acc_cnt; d0 = vga_done_cnt; a0 = cpu_ack_cnt;
        for (int i = 0; i < 8; i++) push_vga(22'h002000 + 22'(i));
        vga_addr = 22'h002000; vga_len = 10'd8; vga_req = 1'b1;
        for (int n = 0; n < 50 && rd_acc_cnt < r0 + 3; n++) tick();
        check("midrst_three_issued", rd_acc_cnt - r0, 3);
        reset = 1'b1; vga_req = 1'b0;
        addr_exp.delete(); vga_exp.delete();
        tick();
        check_zero("midrst");
        reset = 1'b0;
        ticks(12);
        check("midrst_late_drained", rq.size(), 0);
        check("midrst_no_done", vga_done_cnt, d0);
        check("midrst_no_ack", cpu_ack_cnt, a0);
        cpu_we = 1'b0; cpu_addr = 22'h000100; cpu_rd_exp = 1'b1; cpu_exp_addr = 22'h000100; cpu_req = 1'b1;
        run_until(d0, a0 + 1, 40, "midrst_cpu");
        check("midrst_cpu_data", ack_rdata, 16'hBEEF);
        ticks(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single pipelined SDRAM controller port between two requesters: the VGA line-fetch engine and the CPU load/store path.
- VGA bursts are latency-critical and are granted first. A VGA burst cannot be interrupted once granted.
- Alternating priority guarantees the CPU one access between consecutive VGA bursts.
- Sits in top between the CPU/VGA blocks and the SDRAM controller that drives the DRAM_* pins.

Parameters:
- ADDR_W, 22, word address width on all address ports.
- DATA_W, 16, SDRAM data width.
- LEN_W, 10, width of the VGA burst length field (max 1023 words).
- MAX_PENDING, 7, maximum reads in flight at the SDRAM controller.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_be  in  2  CPU byte enables
- cpu_ack  out  1  one-cycle pulse: access complete
- cpu_rdata  out  DATA_W  read data; valid with cpu_ack on reads
- vga_req  in  1  burst request; held until vga_done
- vga_addr  in  ADDR_W  burst start address; latched at grant
- vga_len  in  LEN_W  burst length in words; latched at grant
- vga_data  out  DATA_W  returned burst word
- vga_data_valid  out  1  vga_data valid, in address order
- vga_done  out  1  one-cycle pulse: last burst word delivered
- sd_addr  out  ADDR_W  controller address
- sd_read  out  1  controller read command
- sd_write  out  1  controller write command
- sd_wdata  out  DATA_W  controller write data
- sd_be  out  2  controller byte enables
- sd_waitrequest  in  1  controller stall; command held while high
- sd_rdata  in  DATA_W  controller read data
- sd_rdvalid  in  1  controller read data valid

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0.
  - Pending counter, issue counter and return counter 0.
  - Priority flag = VGA.
- Commands: an sd_read/sd_write is accepted on any cycle where it is high and sd_waitrequest is low. Command signals hold stable while stalled.
- Pending counter:
  - +1 on an accepted read.
  - −1 on sd_rdvalid.
  - Both on the same cycle: net 0.
  - No read is issued while pending == MAX_PENDING.
- States:
  - IDLE:
    - If vga_req and (priority == VGA or !cpu_req): latch vga_addr and vga_len, go to VGA_ISSUE.
    - Else if cpu_req: latch the CPU request, go to CPU_CMD.
  - VGA_ISSUE:
    - sd_read asserted; sd_addr = latched address + issue count, wrapping mod 2^ADDR_W.
    - After vga_len reads are accepted, go to VGA_DRAIN.
  - VGA_DRAIN:
    - Wait until return count == vga_len.
    - Then pulse vga_done on the following cycle, set priority = CPU, go to IDLE.
  - CPU_CMD:
    - Drive one command.
    - A write, once accepted, goes to CPU_DONE.
    - A read, once accepted, goes to CPU_WAIT.
  - CPU_WAIT: on sd_rdvalid, latch cpu_rdata, go to CPU_DONE.
  - CPU_DONE: cpu_ack = 1 for exactly one cycle, set priority = VGA, go to IDLE.
- Read-data routing:
  - During VGA_ISSUE/VGA_DRAIN, sd_rdvalid drives vga_data_valid combinationally (zero added latency) and sd_rdata drives vga_data.
  - In CPU_WAIT, read data goes to the CPU.
- Latency:
  - CPU write ack arrives 1 cycle after acceptance.
  - CPU read ack arrives 1 cycle after sd_rdvalid.
  - A VGA burst starts 1 cycle after grant from IDLE.
- Boundary conditions:
  - vga_len == 0: no SDRAM command is issued; vga_done pulses 2 cycles after grant.
  - cpu_req and vga_req both rising in IDLE with priority == VGA: VGA is granted. The CPU is served immediately after that burst.
  - sd_rdvalid arriving in IDLE or CPU_CMD: this is a protocol error; the data is dropped and the pending counter saturates at 0.
  - reset mid-burst or mid-access: everything returns to reset values. Data returning after reset is dropped per the previous rule, and no ack or done is produced.
  - cpu_req deasserted before ack: this is a protocol violation; the arbiter completes the latched access anyway.

Optional Feature:
- Macro: SDRAM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_cpu_wait_max (16 bits) and stat_vga_bursts (16 bits).
  - stat_cpu_wait_max holds the maximum cycle count from cpu_req rising to cpu_ack, saturating.
  - stat_vga_bursts counts vga_done pulses, wrapping.
  - Both clear on reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - the state encoding localparams (IDLE, VGA_ISSUE, VGA_DRAIN, CPU_CMD, CPU_WAIT, CPU_DONE);
  - the DATA_W and ADDR_W defaults, shared with the SDRAM controller wrapper.
- One sub-module: sdram_arb_pending_ctr, the up/down in-flight read counter with full flag.

Test Plan:
- CPU write only (addr 0x000100, data 0xBEEF, be 2'b11):
  - exactly one sd_write with those values;
  - cpu_ack pulses 1 cycle after acceptance.
- CPU read of 0x000100 with the memory model holding 0xBEEF:
  - cpu_rdata = 0xBEEF with a single cpu_ack pulse.
- VGA burst (addr 0x3FFFFE, len 4), waitrequest toggled every other cycle:
  - addresses 0x3FFFFE, 0x3FFFFF, 0x000000, 0x000001;
  - 4 vga_data_valid pulses in order;
  - one vga_done pulse.
- cpu_req and vga_req asserted in the same cycle from reset:
  - VGA burst of 8 completes first, then the CPU access;
  - a second vga_req waits for cpu_ack.
- Read latency 12 cycles with MAX_PENDING = 7, burst of 20: pending never exceeds 7 and all 20 words return.
- reset pulsed mid-burst after 3 of 8 reads:
  - all outputs 0 next cycle;
  - late sd_rdvalid ignored;
  - no vga_done;
  - a subsequent CPU read succeeds.
